// File: rtl/exe_wb_queue.sv
// ============================================================================
// exe_wb_queue : in-order queue between execute and writeback; drains beats
//                into GPR / RFLAGS write strobes, splitting 128-bit results.
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module exe_wb_queue #(
  parameter int         DEPTH  = 4,
  parameter logic [3:0] HI_REG = 4'd2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       exe_mem,
  input  logic [127:0]               result,
  input  logic [63:0]                rflags,
  input  logic [3:0]                 dst_reg,
  input  logic                       dst_valid,
  input  logic                       wide,
  input  logic                       flags_valid,
  output logic                       mem_blocked,
  input  logic                       wb_stall,
  output logic                       gpr_we,
  output logic [3:0]                 gpr_waddr,
  output logic [63:0]                gpr_wdata,
  output logic                       rflags_we,
  output logic [63:0]                rflags_out,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int              AW   = $clog2(DEPTH);
  localparam int              CW   = AW + 1;
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);
  localparam logic [CW-1:0]   HIGH = CW'(DEPTH - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, WB_HI = 1'b1} state_t;
  state_t state, state_next;

  logic [127:0] q_result [DEPTH];
  logic [63:0]  q_flags  [DEPTH];
  logic [3:0]   q_dst    [DEPTH];
  logic         q_dv     [DEPTH];
  logic         q_wide   [DEPTH];
  logic         q_fv     [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  logic          we_next, rwe_next;
  logic [3:0]    waddr_next;
  logic [63:0]   wdata_next, rout_next;

  assign push        = exe_mem && (count != FULL);
  assign mem_blocked = (count >= HIGH);

  // Payload storage carries no reset; validity is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      q_result[wr_ptr] <= result;
      q_flags[wr_ptr]  <= rflags;
      q_dst[wr_ptr]    <= dst_reg;
      q_dv[wr_ptr]     <= dst_valid;
      q_wide[wr_ptr]   <= wide;
      q_fv[wr_ptr]     <= flags_valid;
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    we_next    = 1'b0;
    rwe_next   = 1'b0;
    waddr_next = gpr_waddr;
    wdata_next = gpr_wdata;
    rout_next  = rflags_out;
    if (!wb_stall) begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            we_next    = q_dv[rd_ptr];
            waddr_next = q_dst[rd_ptr];
            wdata_next = q_result[rd_ptr][63:0];
            rwe_next   = q_fv[rd_ptr];
            rout_next  = q_flags[rd_ptr];
            // Wide entries stay at the head until the high half is written.
            if (q_wide[rd_ptr]) state_next = WB_HI;
            else                pop        = 1'b1;
          end
        end
        WB_HI: begin
          we_next    = 1'b1;
          waddr_next = HI_REG;
          wdata_next = q_result[rd_ptr][127:64];
          pop        = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      gpr_we     <= 1'b0;
      gpr_waddr  <= '0;
      gpr_wdata  <= '0;
      rflags_we  <= 1'b0;
      rflags_out <= '0;
    end else begin
      state      <= state_next;
      gpr_we     <= we_next;
      gpr_waddr  <= waddr_next;
      gpr_wdata  <= wdata_next;
      rflags_we  <= rwe_next;
      rflags_out <= rout_next;
      if (exe_mem && (count == FULL)) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_exe_wb_queue.sv
// ============================================================================
// tb_exe_wb_queue : directed self-checking bench for exe_wb_queue.
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_exe_wb_queue;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         exe_mem = 1'b0;
  logic [127:0] result = '0;
  logic [63:0]  rflags = '0;
  logic [3:0]   dst_reg = '0;
  logic         dst_valid = 1'b0;
  logic         wide = 1'b0;
  logic         flags_valid = 1'b0;
  logic         mem_blocked;
  logic         wb_stall = 1'b0;
  logic         gpr_we;
  logic [3:0]   gpr_waddr;
  logic [63:0]  gpr_wdata;
  logic         rflags_we;
  logic [63:0]  rflags_out;
  logic [2:0]   count;
  logic         overflow;

  int n_checks = 0;
  int n_pass   = 0;

  exe_wb_queue #(.DEPTH(4), .HI_REG(4'd2)) dut (
    .clk(clk), .reset_n(reset_n), .exe_mem(exe_mem), .result(result),
    .rflags(rflags), .dst_reg(dst_reg), .dst_valid(dst_valid), .wide(wide),
    .flags_valid(flags_valid), .mem_blocked(mem_blocked), .wb_stall(wb_stall),
    .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .rflags_we(rflags_we), .rflags_out(rflags_out), .count(count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [127:0] r, input logic [63:0] f, input logic [3:0] d,
                      input logic dv, input logic wd, input logic fv);
    exe_mem = 1'b1; result = r; rflags = f; dst_reg = d;
    dst_valid = dv; wide = wd; flags_valid = fv;
  endtask

  task automatic do_reset();
    exe_mem = 1'b0; wb_stall = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    step();
  endtask

  int rx, tx;

  initial begin
    // Reset state
    #12 reset_n = 1'b1;
    check("rst_count", count, 0);
    check("rst_gpr_we", gpr_we, 0);
    check("rst_rflags_we", rflags_we, 0);
    check("rst_overflow", overflow, 0);
    check("rst_blocked", mem_blocked, 0);

    // Single narrow beat: strobes one edge after acceptance
    step();
    beat(128'h5, 64'h46, 4'd3, 1'b1, 1'b0, 1'b1);
    step();
    check("s_count1", count, 1);
    check("s_we_early", gpr_we, 0);
    exe_mem = 1'b0;
    step();
    check("s_we", gpr_we, 1);
    check("s_waddr", gpr_waddr, 3);
    check("s_wdata", gpr_wdata, 5);
    check("s_rwe", rflags_we, 1);
    check("s_rflags", rflags_out, 64'h46);
    check("s_count0", count, 0);
    step();
    check("s_we_off", gpr_we, 0);

    // Wide beat: low half to dst_reg, then high half to reg 2
    beat({64'h1, 64'hFFFF_FFFF_FFFF_FFFE}, 64'h80, 4'd0, 1'b1, 1'b1, 1'b1);
    step();
    exe_mem = 1'b0;
    step();
    check("w_lo_we", gpr_we, 1);
    check("w_lo_addr", gpr_waddr, 0);
    check("w_lo_data", gpr_wdata, 64'hFFFF_FFFF_FFFF_FFFE);
    check("w_lo_rwe", rflags_we, 1);
    check("w_lo_count", count, 1);
    step();
    check("w_hi_we", gpr_we, 1);
    check("w_hi_addr", gpr_waddr, 2);
    check("w_hi_data", gpr_wdata, 64'h1);
    check("w_hi_rwe", rflags_we, 0);
    check("w_hi_count", count, 0);
    step();
    check("w_we_off", gpr_we, 0);

    // Fill under stall, overflow on the fifth beat
    wb_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      beat(128'h20 + 128'(i), 64'h0, 4'(i + 4), 1'b1, 1'b0, 1'b0);
      step();
      check("f_stall_we", gpr_we, 0);
      if (i == 1) check("f_blk2", mem_blocked, 0);
      if (i == 2) begin check("f_cnt3", count, 3); check("f_blk3", mem_blocked, 1); end
      if (i == 3) begin check("f_cnt4", count, 4); check("f_ovf_no", overflow, 0); end
      if (i == 4) begin check("f_cnt_hold", count, 4); check("f_ovf", overflow, 1); end
    end
    exe_mem = 1'b0;
    wb_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("f_d_we", gpr_we, 1);
      check("f_d_addr", gpr_waddr, 4'(i + 4));
      check("f_d_data", gpr_wdata, 64'h20 + 64'(i));
      check("f_d_cnt", count, 3 - i);
    end
    check("f_ovf_sticky", overflow, 1);

    // Stream 8 narrow beats with wb_stall toggling
    do_reset();
    check("st_ovf_clr", overflow, 0);
    rx = 0; tx = 0;
    for (int cyc = 0; cyc < 80 && rx < 8; cyc++) begin
      wb_stall = (cyc % 2) == 1;
      if (tx < 8 && !mem_blocked) begin
        beat(128'h100 + 128'(tx), 64'h0, 4'(tx), 1'b1, 1'b0, 1'b0);
        tx++;
      end else exe_mem = 1'b0;
      step();
      if (gpr_we) begin
        check("st_addr", gpr_waddr, 4'(rx));
        check("st_data", gpr_wdata, 64'h100 + 64'(rx));
        rx++;
      end
    end
    exe_mem = 1'b0; wb_stall = 1'b0;
    check("st_received", rx, 8);
    check("st_count", count, 0);
    check("st_ovf", overflow, 0);
    step();
    check("st_no_dup", gpr_we, 0);

    // Push and pop on the same edge at count 2
    do_reset();
    wb_stall = 1'b1;
    beat(128'hA, 64'h0, 4'd1, 1'b1, 1'b0, 1'b0); step();
    beat(128'hB, 64'h0, 4'd1, 1'b1, 1'b0, 1'b0); step();
    check("pp_cnt2", count, 2);
    wb_stall = 1'b0;
    beat(128'hC, 64'h0, 4'd1, 1'b1, 1'b0, 1'b0); step();
    check("pp_cnt_hold", count, 2);
    check("pp_a", gpr_wdata, 64'hA);
    exe_mem = 1'b0;
    step();
    check("pp_b", gpr_wdata, 64'hB);
    check("pp_cnt1", count, 1);
    step();
    check("pp_c", gpr_wdata, 64'hC);
    check("pp_cnt0", count, 0);

    // Asynchronous reset while in WB_HI with 3 entries
    do_reset();
    wb_stall = 1'b1;
    beat({64'hDEAD, 64'h1}, 64'h0, 4'd5, 1'b1, 1'b1, 1'b0); step();
    beat(128'h2, 64'h0, 4'd6, 1'b1, 1'b0, 1'b0); step();
    beat(128'h3, 64'h0, 4'd7, 1'b1, 1'b0, 1'b1); step();
    exe_mem = 1'b0;
    wb_stall = 1'b0;
    step();
    check("ar_lo_we", gpr_we, 1);
    check("ar_cnt3", count, 3);
    #3 reset_n = 1'b0;
    #1;
    check("ar_we", gpr_we, 0);
    check("ar_waddr", gpr_waddr, 0);
    check("ar_wdata", gpr_wdata, 0);
    check("ar_count", count, 0);
    check("ar_rout", rflags_out, 0);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ar_no_wr", gpr_we, 0);
      check("ar_cnt_post", count, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
